// File: rtl/prince_ti_pkg.sv
// Shared constants for the threshold-implementation A-box: affine constants, mode
// encodings and the legal parameter ranges of masked_abox_pipe.
package prince_ti_pkg;

    localparam logic [3:0] AFFINE_CONST_FWD = 4'b0101;
    // Inverse constant: the forward constant pushed back through the inverse linear map.
    localparam logic [3:0] AFFINE_CONST_INV = 4'b1011;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    localparam int SHARES_MIN  = 2;
    localparam int SHARES_MAX  = 8;
    localparam int NIBBLES_MIN = 1;
    localparam int NIBBLES_MAX = 16;
    localparam int STAGES_MIN  = 1;
    localparam int STAGES_MAX  = 4;

    function automatic logic [3:0] affine_const(input logic mode);
        return (mode == MODE_INV) ? AFFINE_CONST_INV : AFFINE_CONST_FWD;
    endfunction

endpackage

// File: rtl/masked_abox_pipe_affine.sv
// One share of one nibble through the forward or inverse A-box affine map.
// Only share 0 receives the constant, so each instance sees a single share.
module abox_affine
    import prince_ti_pkg::*;
(
    input  logic [3:0] x,
    input  logic       mode,
    input  logic       const_en,
    output logic [3:0] z
);

    logic [3:0] lin;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        if (mode == MODE_FWD) begin
            lin = {x[2], x[3], x[0] ^ x[1] ^ x[2], x[1]};
        end else begin
            lin = {x[2], x[3], x[0], x[0] ^ x[1] ^ x[3]};
        end
        z = lin ^ (const_en ? affine_const(mode) : 4'b0000);
    end

endmodule

// File: rtl/masked_abox_pipe.sv
// Masked A-box affine layer with a STAGES-deep valid/ready pipeline.
// Optional share refresh with an external rnd port: define MASKED_ABOX_REFRESH_EN.
module masked_abox_pipe
    import prince_ti_pkg::*;
#(
    parameter int SHARES  = 4,
    parameter int NIBBLES = 16,
    parameter int STAGES  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_mode,
    input  logic [SHARES*NIBBLES*4-1:0]   in_data,
`ifdef MASKED_ABOX_REFRESH_EN
    input  logic [(SHARES-1)*NIBBLES*4-1:0] rnd,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SHARES*NIBBLES*4-1:0]   out_data
);

    localparam int W  = SHARES * NIBBLES * 4;
    localparam int LW = NIBBLES * 4;

    if (SHARES < SHARES_MIN || SHARES > SHARES_MAX ||
        NIBBLES < NIBBLES_MIN || NIBBLES > NIBBLES_MAX ||
        STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_param_err
        $error("masked_abox_pipe: parameter out of legal range");
    end

    logic [W-1:0] xform;
    logic [W-1:0] load_word;

    for (genvar s = 0; s < SHARES; s++) begin : g_share
        for (genvar n = 0; n < NIBBLES; n++) begin : g_lane
            abox_affine u_abox (
                .x        (in_data[(s*NIBBLES+n)*4 +: 4]),
                .mode     (in_mode),
                .const_en (1'(s == 0)),
                .z        (xform[(s*NIBBLES+n)*4 +: 4])
            );
        end
    end

`ifdef MASKED_ABOX_REFRESH_EN
    logic [LW-1:0] rnd_sum;

    // The last share absorbs the XOR of all masks, so the unmasked value is unchanged.
    always_comb begin
        rnd_sum = '0;
        for (int s = 0; s < SHARES - 1; s++) begin
            rnd_sum = rnd_sum ^ rnd[s*LW +: LW];
        end
        load_word = xform ^ {rnd_sum, rnd};
    end
`else
    assign load_word = xform;
`endif

    // Mode is consumed at slot 0's input, so each word already carries its own transform.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [W-1:0]      data_q [STAGES];
    logic [W-1:0]      data_d [STAGES];
    logic [STAGES:0]   take;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] ld;

    always_comb begin
        // take[k]: slot k can accept a word this cycle; resolved backward from out_ready.
        take[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = valid_q[k] & take[k+1];
            take[k] = ~valid_q[k] | adv[k];
        end

        ld[0]     = in_valid & take[0];
        data_d[0] = ld[0] ? load_word : data_q[0];
        for (int k = 1; k < STAGES; k++) begin
            ld[k]     = adv[k-1];
            data_d[k] = ld[k] ? data_q[k-1] : data_q[k];
        end

        valid_d = ld | (valid_q & ~adv);
    end

    // NOTE: the data slots are reset too, because out_data must read 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = take[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_masked_abox_pipe.sv
// Self-checking bench: word-level reference model with a scoreboard queue, plus
// directed scenarios for latency, back-pressure, mode alternation and reset.
module tb_masked_abox_pipe;

    localparam int SH = 4;
    localparam int NB = 4;
    localparam int ST = 3;
    localparam int W  = SH * NB * 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef MASKED_ABOX_REFRESH_EN
    logic [(SH-1)*NB*4-1:0] rnd = '0;
`endif

    int tests  = 0;
    int fails  = 0;
    int out_cnt = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    masked_abox_pipe #(.SHARES(SH), .NIBBLES(NB), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
`ifdef MASKED_ABOX_REFRESH_EN
        .rnd       (rnd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference A-box written straight from the bit equations; c is the share-0 constant.
    function automatic logic [3:0] ref_nib(input logic [3:0] x, input logic inv, input logic c);
        logic [3:0] z;
        if (!inv) begin
            z[0] = x[1] ^ c;
            z[1] = x[0] ^ x[1] ^ x[2];
            z[2] = x[3] ^ c;
            z[3] = x[2];
        end else begin
            z[0] = x[0] ^ x[1] ^ x[3] ^ c;
            z[1] = x[0] ^ c;
            z[2] = x[3];
            z[3] = x[2] ^ c;
        end
        return z;
    endfunction

    function automatic logic [W-1:0] ref_word(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int s = 0; s < SH; s++)
            for (int n = 0; n < NB; n++)
                r[(s*NB+n)*4 +: 4] = ref_nib(d[(s*NB+n)*4 +: 4], inv, s == 0);
        return r;
    endfunction

    function automatic logic [NB*4-1:0] unmask(input logic [W-1:0] d);
        logic [NB*4-1:0] u = '0;
        for (int s = 0; s < SH; s++) u = u ^ d[s*NB*4 +: NB*4];
        return u;
    endfunction

    function automatic logic [W-1:0] make_word(input logic [NB*4-1:0] vals);
        logic [W-1:0] w;
        logic [3:0]   acc, m;
        for (int n = 0; n < NB; n++) begin
            acc = vals[n*4 +: 4];
            for (int s = 1; s < SH; s++) begin
                m = 4'($urandom);
                w[(s*NB+n)*4 +: 4] = m;
                acc = acc ^ m;
            end
            w[n*4 +: 4] = acc;
        end
        return w;
    endfunction

    // Scoreboard: pushes accepted words through the model, pops on output transfers,
    // and checks that a stalled output holds still.
    logic         hold_v = 1'b0;
    logic [W-1:0] hold_d;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, hold_d);
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
                else check("out_data", out_data, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(ref_word(in_data, in_mode));
        end
    end

    // Send one word with out_ready high and return the output word and its latency.
    task automatic send_get(input logic [W-1:0] d, input logic m,
                            output logic [W-1:0] res, output int lat);
        logic acc = 1'b0;
        in_data = d; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 64'd1, 64'd0);
        lat = 0; res = '0;
        for (int n = 1; n <= 30; n++) begin
            if (out_valid) begin lat = n; res = out_data; break; end
            @(posedge clk); #1;
        end
        if (lat == 0) check("output_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic cycle_accept(output logic acc);
        @(negedge clk); acc = in_valid && in_ready;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, r2, w0;
        int lat, acc_cnt, base, vcnt;
        logic acc;
        logic [NB*4-1:0] vals;

        rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;

        // Model pinned against hand-computed nibbles.
        check("model_fwd_0_share0", 64'(ref_nib(4'h0, 1'b0, 1'b1)), 64'h5);
        check("model_fwd_F", 64'(ref_nib(4'hF, 1'b0, 1'b1)), 64'hA);
        check("model_inv_A", 64'(ref_nib(4'hA, 1'b1, 1'b1)), 64'hF);
        check("model_inv_5", 64'(ref_nib(4'h5, 1'b1, 1'b1)), 64'h0);

        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // All-zero shares, forward: share 0 lanes read 5, others 0, after STAGES cycles.
        send_get('0, 1'b0, r, lat);
        check("zero_fwd_data", r, 64'h0000_0000_0000_5555);
        check("zero_fwd_latency", 64'(lat), 64'(ST));

        // Unmasked F forward -> A; A inverse -> F; 5 inverse -> 0.
        send_get(make_word(16'hFFFF), 1'b0, r, lat);
        check("fwd_F_unmasked", 64'(unmask(r)), 64'hAAAA);
        send_get(make_word(16'hAAAA), 1'b1, r, lat);
        check("inv_A_unmasked", 64'(unmask(r)), 64'hFFFF);
        send_get(make_word(16'h5555), 1'b1, r, lat);
        check("inv_5_unmasked", 64'(unmask(r)), 64'h0000);

        // Round trip for every value and both starting modes.
        for (int v = 0; v < 16; v++) begin
            for (int md = 0; md < 2; md++) begin
                vals = {4'(v ^ 9), 4'(v + 3), ~4'(v), 4'(v)};
                send_get(make_word(vals), 1'(md), r, lat);
                check("rt_latency", 64'(lat), 64'(ST));
                send_get(r, ~1'(md), r2, lat);
                check("rt_value", 64'(unmask(r2)), 64'(vals));
            end
        end

        // Back-pressure: output stalled 5 cycles with continuous input.
        base = out_cnt; acc_cnt = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b0;
        w0 = make_word(16'h1234); in_data = w0;
        for (int i = 0; i < 5; i++) begin
            cycle_accept(acc);
            if (acc) begin acc_cnt++; in_data = make_word(16'($urandom)); in_mode = ~in_mode; end
        end
        check("stall_accepted", 64'(acc_cnt), 64'd3);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_head_data", out_data, ref_word(w0, 1'b0));
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) begin
            @(posedge clk); #1;
        end
        check("stall_released", 64'(out_cnt - base), 64'd3);

        // Alternating mode, full throughput.
        base = out_cnt; acc_cnt = 0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = make_word(16'($urandom)); in_mode = 1'(i);
            cycle_accept(acc);
            if (acc) acc_cnt++;
        end
        in_valid = 1'b0;
        check("alt_accepted", 64'(acc_cnt), 64'd8);
        repeat (ST) cycle_accept(acc);
        check("alt_outputs", 64'(out_cnt - base), 64'd8);

        // Reset with two words in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = make_word(16'($urandom)); cycle_accept(acc);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0; #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; out_ready = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) vcnt++;
        end
        check("post_rst_no_stale", 64'(vcnt), 64'd0);
        w0 = make_word(16'hC0DE);
        send_get(w0, 1'b1, r, lat);
        check("post_rst_latency", 64'(lat), 64'(ST));
        check("post_rst_data", r, ref_word(w0, 1'b1));

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
